pack_mod: RTL and testbench
===========================

PACK_MOD -- requirements
Module: pack_mod

Interface
REQ-001 Parameter W, default 32, datapath width of all operands and results.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rstn  input  1  reset, synchronous, active-low.
REQ-004 gen  input  1  start request, sampled only in IDLE.
REQ-005 m0, m1  input  W  sender plaintext messages, each < N.
REQ-006 x0, x1  input  W  sender random values previously published, each < N.
REQ-007 v  input  W  blinded value returned by receiver, < N.
REQ-008 d  input  W  RSA private exponent.
REQ-009 N  input  W  RSA modulus, N >= 2.
REQ-010 message0, message1  output  W  packed messages m0', m1'.
REQ-011 gen_end  output  1  one-cycle completion pulse.

Function
REQ-012 Block SHALL compute k0 = ((v - x0) mod N)^d mod N and k1 = ((v - x1) mod N)^d mod N.
REQ-013 Block SHALL output message0 = (m0 + k0) mod N and message1 = (m1 + k1) mod N.
REQ-014 States SHALL be IDLE, PREP0, EXP0, PREP1, EXP1, ADD, DONE.
REQ-015 IDLE: when gen=1, latch m0, m1, x0, x1, v, d, N into internal registers and go to PREP0; otherwise stay in IDLE.
REQ-016 PREP0: base = v-x0 if v >= x0, else v-x0+N; assert md_start for exactly one cycle; go to EXP0.
REQ-017 EXP0: hold md_start=0; on md_end=1, capture r as k0 and go to PREP1.
REQ-018 PREP1/EXP1: same as PREP0/EXP0 using x1, capturing k1; on md_end, go to ADD.
REQ-019 ADD: form each sum at W+1 bits; subtract N once if sum >= N; register into message0/message1; go to DONE.
REQ-020 DONE: gen_end=1 for exactly this cycle; go to IDLE.
REQ-021 message0/message1 SHALL hold their values from ADD until the next ADD or reset.
REQ-022 gen SHALL be ignored in every state except IDLE; internal operand registers SHALL not change while busy.
REQ-023 gen held high continuously SHALL cause back-to-back operations: DONE -> IDLE -> accept on the next cycle.
REQ-024 Latency from gen accept to gen_end SHALL be 5 cycles plus the two exponentiation latencies.
REQ-025 Exponentiator modulus SHALL be driven from latched N, never from the live N port.
REQ-026 Results are undefined if any operand is >= N or N < 2; the FSM SHALL still terminate.

Reset
REQ-027 rstn=0 SHALL force IDLE, md_start=0, gen_end=0, message0=0, message1=0.
REQ-028 Reset asserted mid-operation SHALL abort with no gen_end pulse.
REQ-029 After a mid-operation reset, a stale md_end from the exponentiator SHALL be ignored in IDLE.

Structure
REQ-030 The shared package SHALL hold the state encoding (3-bit) and the default W.
REQ-031 Exactly one sub-module, RL_binary, SHALL be instantiated and time-shared for both exponentiations.
REQ-032 RL_binary ports: md_start, base, exp, modulus, r, md_end; md_end is a single-cycle pulse.

Verification
REQ-033 N=33, d=7, v=20, x0=5, x1=9, m0=10, m1=30 -> k0=27, k1=11; message0=4, message1=8; one gen_end pulse.
REQ-034 N=33, d=7, v=3, x0=5, x1=3, m0=0, m1=32 -> subtraction wrap gives base 31, k0=4, k1=0; message0=4, message1=32.
REQ-035 N=0xFFFFFFFB, d=1, v=0xFFFFFFFA, x0=0, x1=0xFFFFFFFA, m0=0xFFFFFFF0, m1=5 -> message0=0xFFFFFFEF (carry into bit W), message1=5.
REQ-036 gen held high and operand ports changed during EXP0 -> results match the latched operands; the next operation starts one cycle after DONE.
REQ-037 rstn pulsed low during EXP1 -> outputs 0, no gen_end; a subsequent gen with the REQ-033 vectors gives 4/8.

Source files
------------

// File: rtl/pack_mod_pkg.sv
// Shared definitions for the pack_mod oblivious-transfer packing block:
// default datapath width and the controller state encoding.
package pack_mod_pkg;

  localparam int W_DEF = 32;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_PREP0 = 3'd1;
  localparam logic [2:0] ST_EXP0  = 3'd2;
  localparam logic [2:0] ST_PREP1 = 3'd3;
  localparam logic [2:0] ST_EXP1  = 3'd4;
  localparam logic [2:0] ST_ADD   = 3'd5;
  localparam logic [2:0] ST_DONE  = 3'd6;

endpackage

// File: rtl/pack_mod_if.sv
// Operand/result bundle between the requester and pack_mod.
interface pack_mod_if #(parameter int W = pack_mod_pkg::W_DEF);

  logic         gen;
  logic [W-1:0] m0;
  logic [W-1:0] m1;
  logic [W-1:0] x0;
  logic [W-1:0] x1;
  logic [W-1:0] v;
  logic [W-1:0] d;
  logic [W-1:0] N;
  logic [W-1:0] message0;
  logic [W-1:0] message1;
  logic         gen_end;

  modport master (
    output gen, m0, m1, x0, x1, v, d, N,
    input  message0, message1, gen_end
  );

  modport slave (
    input  gen, m0, m1, x0, x1, v, d, N,
    output message0, message1, gen_end
  );

endinterface

// File: rtl/pack_mod_rl_binary.sv
// Right-to-left binary modular exponentiator. Each exponent bit runs the
// square and the conditional multiply side by side as W-step shift-add loops.
module RL_binary
  import pack_mod_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         md_start,
  input  logic [W-1:0] base,
  input  logic [W-1:0] exp,
  input  logic [W-1:0] modulus,
  output logic [W-1:0] r,
  output logic         md_end
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  // One MSB-first step of acc*2 + bit*a (mod m); needs acc < m and a < m.
  function automatic logic [W-1:0] dbl_add(input logic [W-1:0] acc,
                                            input logic [W-1:0] a,
                                            input logic [W-1:0] m,
                                            input logic         bit_i);
    logic [W:0] t;
    t = {acc, 1'b0};
    if (t >= {1'b0, m}) t = t - {1'b0, m};
    if (bit_i) begin
      t = t + {1'b0, a};
      if (t >= {1'b0, m}) t = t - {1'b0, m};
    end
    return t[W-1:0];
  endfunction

  logic          busy_q, busy_d;
  logic          md_end_q, md_end_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  r_q, r_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  e_q, e_d;
  logic [W-1:0]  acc_r_q, acc_r_d;
  logic [W-1:0]  acc_b_q, acc_b_d;
  logic [W-1:0]  nr, nb;
  logic          mbit;

  assign mbit = b_q[cnt_q];
  assign nr   = dbl_add(acc_r_q, r_q, modulus, mbit);
  assign nb   = dbl_add(acc_b_q, b_q, modulus, mbit);

  always_comb begin
    busy_d   = busy_q;
    md_end_d = 1'b0;
    cnt_d    = cnt_q;
    r_d      = r_q;
    b_d      = b_q;
    e_d      = e_q;
    acc_r_d  = acc_r_q;
    acc_b_d  = acc_b_q;
    if (md_start) begin
      busy_d  = 1'b1;
      r_d     = W'(1);
      b_d     = base;
      e_d     = exp;
      cnt_d   = CW'(W-1);
      acc_r_d = '0;
      acc_b_d = '0;
    end else if (busy_q) begin
      if (e_q == '0) begin
        busy_d   = 1'b0;
        md_end_d = 1'b1;
      end else if (cnt_q == '0) begin
        // Last multiplier bit: commit r*b (if exponent bit set) and b*b.
        if (e_q[0]) r_d = nr;
        b_d     = nb;
        e_d     = e_q >> 1;
        cnt_d   = CW'(W-1);
        acc_r_d = '0;
        acc_b_d = '0;
      end else begin
        acc_r_d = nr;
        acc_b_d = nb;
        cnt_d   = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      busy_q   <= 1'b0;
      md_end_q <= 1'b0;
      cnt_q    <= '0;
      r_q      <= '0;
      b_q      <= '0;
      e_q      <= '0;
      acc_r_q  <= '0;
      acc_b_q  <= '0;
    end else begin
      busy_q   <= busy_d;
      md_end_q <= md_end_d;
      cnt_q    <= cnt_d;
      r_q      <= r_d;
      b_q      <= b_d;
      e_q      <= e_d;
      acc_r_q  <= acc_r_d;
      acc_b_q  <= acc_b_d;
    end
  end

  assign r      = r_q;
  assign md_end = md_end_q;

endmodule

// File: rtl/pack_mod.sv
// Packs two messages with RSA-derived keys: message_i = m_i + ((v-x_i)^d mod N)
// mod N, sharing one exponentiator across both keys.
module pack_mod
  import pack_mod_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic      clk,
  input  logic      rstn,
  pack_mod_if.slave bus
);

  logic [2:0]   state_q, state_d;
  logic [W-1:0] m0_q, m0_d, m1_q, m1_d;
  logic [W-1:0] x0_q, x0_d, x1_q, x1_d;
  logic [W-1:0] v_q, v_d, d_q, d_d, n_q, n_d;
  logic [W-1:0] k0_q, k0_d, k1_q, k1_d;
  logic [W-1:0] msg0_q, msg0_d, msg1_q, msg1_d;

  logic         md_start, md_end;
  logic [W-1:0] base, r, x_sel;
  logic [W:0]   sum0, sum1, n_ext;

  // Wrapping W-bit subtraction yields v-x+N exactly when v < x.
  assign x_sel    = (state_q == ST_PREP1) ? x1_q : x0_q;
  assign base     = (v_q >= x_sel) ? (v_q - x_sel) : (v_q - x_sel + n_q);
  assign md_start = (state_q == ST_PREP0) || (state_q == ST_PREP1);

  assign n_ext = {1'b0, n_q};
  assign sum0  = {1'b0, m0_q} + {1'b0, k0_q};
  assign sum1  = {1'b0, m1_q} + {1'b0, k1_q};

  RL_binary #(.W(W)) u_rl (
    .clk     (clk),
    .rstn    (rstn),
    .md_start(md_start),
    .base    (base),
    .exp     (d_q),
    .modulus (n_q),
    .r       (r),
    .md_end  (md_end)
  );

  always_comb begin
    state_d = state_q;
    m0_d    = m0_q;
    m1_d    = m1_q;
    x0_d    = x0_q;
    x1_d    = x1_q;
    v_d     = v_q;
    d_d     = d_q;
    n_d     = n_q;
    k0_d    = k0_q;
    k1_d    = k1_q;
    msg0_d  = msg0_q;
    msg1_d  = msg1_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.gen) begin
          m0_d    = bus.m0;
          m1_d    = bus.m1;
          x0_d    = bus.x0;
          x1_d    = bus.x1;
          v_d     = bus.v;
          d_d     = bus.d;
          n_d     = bus.N;
          state_d = ST_PREP0;
        end
      end
      ST_PREP0: state_d = ST_EXP0;
      ST_EXP0: begin
        if (md_end) begin
          k0_d    = r;
          state_d = ST_PREP1;
        end
      end
      ST_PREP1: state_d = ST_EXP1;
      ST_EXP1: begin
        if (md_end) begin
          k1_d    = r;
          state_d = ST_ADD;
        end
      end
      ST_ADD: begin
        msg0_d  = (sum0 >= n_ext) ? W'(sum0 - n_ext) : sum0[W-1:0];
        msg1_d  = (sum1 >= n_ext) ? W'(sum1 - n_ext) : sum1[W-1:0];
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      m0_q    <= '0;
      m1_q    <= '0;
      x0_q    <= '0;
      x1_q    <= '0;
      v_q     <= '0;
      d_q     <= '0;
      n_q     <= '0;
      k0_q    <= '0;
      k1_q    <= '0;
      msg0_q  <= '0;
      msg1_q  <= '0;
    end else begin
      state_q <= state_d;
      m0_q    <= m0_d;
      m1_q    <= m1_d;
      x0_q    <= x0_d;
      x1_q    <= x1_d;
      v_q     <= v_d;
      d_q     <= d_d;
      n_q     <= n_d;
      k0_q    <= k0_d;
      k1_q    <= k1_d;
      msg0_q  <= msg0_d;
      msg1_q  <= msg1_d;
    end
  end

  assign bus.message0 = msg0_q;
  assign bus.message1 = msg1_q;
  assign bus.gen_end  = (state_q == ST_DONE);

endmodule

// File: tb/tb_pack_mod.sv
// Scoreboard bench for pack_mod: directed vectors push expected results,
// a negedge monitor pops and checks them on every gen_end pulse.
module tb_pack_mod;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] m0, m1, x0, x1, v, d, n;
  } vec_t;

  typedef struct {
    logic [W-1:0] e0, e1;
  } exp_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  pack_mod_if #(.W(W)) bus ();

  pack_mod #(.W(W)) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  exp_t sb[$];
  exp_t mon_e;
  int   nvec     = 0;
  int   nerr     = 0;
  int   done_cnt = 0;
  int   cyc      = 0;
  int   g_last   = 0;
  logic ge_d     = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    nvec++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (bus.gen_end === 1'b1) begin
      if (ge_d) begin
        nvec++; nerr++;
        $display("FAIL gen_end_width: high on consecutive cycles, required single pulse");
      end
      if (sb.size() == 0) begin
        nvec++; nerr++;
        $display("FAIL spurious_gen_end: pulse at cycle %0d, required none", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("message0", bus.message0, mon_e.e0);
        check("message1", bus.message1, mon_e.e1);
      end
      g_last = cyc;
      done_cnt++;
    end
    ge_d = bus.gen_end;
  end

  task automatic drive(input vec_t t);
    bus.m0 = t.m0; bus.m1 = t.m1; bus.x0 = t.x0; bus.x1 = t.x1;
    bus.v  = t.v;  bus.d  = t.d;  bus.N  = t.n;
  endtask

  task automatic wait_done(input int prev);
    int k;
    k = 0;
    while (done_cnt == prev && k < 20000) begin
      @(posedge clk);
      k++;
    end
    if (done_cnt == prev) begin
      nvec++; nerr++;
      $display("FAIL timeout: no gen_end after %0d cycles, required one", k);
    end
  endtask

  task automatic run_op(input vec_t t, input exp_t e, output int lat);
    int c, prev;
    @(negedge clk);
    drive(t);
    bus.gen = 1'b1;
    sb.push_back(e);
    c    = cyc;
    prev = done_cnt;
    @(negedge clk);
    bus.gen = 1'b0;
    wait_done(prev);
    lat = g_last - (c + 1);
  endtask

  vec_t v1, v2, v3;
  int   l1, l2, l3, l1b, g1, c0, p0;

  initial begin
    v1 = '{m0:32'd10, m1:32'd30, x0:32'd5, x1:32'd9, v:32'd20, d:32'd7, n:32'd33};
    v2 = '{m0:32'd0, m1:32'd32, x0:32'd5, x1:32'd3, v:32'd3, d:32'd7, n:32'd33};
    v3 = '{m0:32'hFFFFFFF0, m1:32'd5, x0:32'd0, x1:32'hFFFFFFFA,
           v:32'hFFFFFFFA, d:32'd1, n:32'hFFFFFFFB};

    bus.gen = 1'b0;
    drive('{m0:'0, m1:'0, x0:'0, x1:'0, v:'0, d:'0, n:'0});
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_message0", bus.message0, '0);
    check("rst_message1", bus.message1, '0);
    check("rst_gen_end", W'(bus.gen_end), '0);
    rstn = 1'b1;

    // Basic vector, then outputs must hold after completion.
    run_op(v1, '{e0:32'd4, e1:32'd8}, l1);
    repeat (5) @(negedge clk);
    check("hold_message0", bus.message0, 32'd4);
    check("hold_message1", bus.message1, 32'd8);

    // v < x0 wrap, zero base for k1.
    run_op(v2, '{e0:32'd4, e1:32'd32}, l2);
    // Sum carries into bit W before reduction.
    run_op(v3, '{e0:32'hFFFFFFEF, e1:32'd5}, l3);

    // gen held high, ports changed mid-operation: back-to-back ops.
    @(negedge clk);
    drive(v1);
    bus.gen = 1'b1;
    sb.push_back('{e0:32'd4, e1:32'd8});
    sb.push_back('{e0:32'd4, e1:32'd32});
    p0 = done_cnt;
    repeat (10) @(negedge clk);
    drive(v2);
    wait_done(p0);
    g1 = g_last;
    @(negedge clk);
    @(negedge clk);
    bus.gen = 1'b0;
    p0 = done_cnt;
    wait_done(p0);
    check("b2b_gap", W'(g_last - g1), W'(2 + l2));

    // Reset during the second exponentiation aborts silently.
    @(negedge clk);
    drive(v1);
    bus.gen = 1'b1;
    c0 = cyc;
    p0 = done_cnt;
    @(negedge clk);
    bus.gen = 1'b0;
    while (cyc < c0 + 1 + (l1 * 3) / 4) @(negedge clk);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_message0", bus.message0, '0);
    check("abort_message1", bus.message1, '0);
    check("abort_gen_end", W'(bus.gen_end), '0);
    rstn = 1'b1;
    repeat (l1 + 10) @(negedge clk);
    check("abort_no_pulse", W'(done_cnt), W'(p0));

    run_op(v1, '{e0:32'd4, e1:32'd8}, l1b);
    check("latency_repeat", W'(l1b), W'(l1));

    repeat (3) @(negedge clk);
    check("sb_drained", W'(sb.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
